fir_decimator: RTL and testbench
================================

# fir_decimator

Downstream stage of the 31-tap low-pass FIR on the voice path. It captures the FIR's 18-bit scaled output on each sample strobe and rounds/saturates it to 8 bits. It keeps every DECIM-th sample (48 kHz to 6 kHz at default) and buffers the kept samples in a small FIFO, which drains to the consumer (recorder/RAM writer) over a valid/ready handshake.

## Interface
- `DECIM`, 8: decimation ratio, ≥1.
- `DEPTH`, 16: FIFO entries, power of two, ≥2.
- `SHIFT`, 10: coefficient scale exponent removed from `y`.
- `clock` in 1: system clock, all logic on rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low (`reset`=0 resets).
- `ready` in 1: one-cycle sample strobe, the same strobe that drives the FIR; ≥32 clocks apart.
- `y` in 18 signed: FIR output, stable and valid at each `ready` for the previous sample.
- `clear` in 1: synchronous flush of FIFO, phase counter and overflow flag.
- `out_valid` out 1: FIFO non-empty.
- `out_data` out 8 signed: head entry, valid when `out_valid`.
- `out_ready` in 1: consumer accepts head this cycle.
- `level` out $clog2(DEPTH+1): current entry count.
- `overflow` out 1: sticky; a kept sample was dropped because FIFO was full.

## Operation
- Priming: the first `ready` after reset is discarded, because the FIR `y` is not yet valid. A `primed` flag sets on it. `clear` does not clear `primed`.
- Conversion on each primed `ready`: sign-extend `y` to 19 bits and add 2^(SHIFT-1). Arithmetic-shift right by SHIFT, giving a 9-bit result. Saturate to [-128, 127].
- Phase counter `phase` runs 0..DECIM-1 and advances once per primed `ready`, wrapping DECIM-1 to 0. A sample is kept when `phase`==0 at that `ready`. The first primed `ready` is always kept.
- FIFO behaviour:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits, plus the `level` counter.
  - Push happens on a kept sample. Pop happens when `out_valid && out_ready`.
  - If pop and push occur in the same cycle with the FIFO full, both proceed, `level` is unchanged and there is no overflow.
  - If a push occurs with the FIFO full and no pop, the new sample is dropped and `overflow` is set to 1. Existing contents are untouched.
  - A pop while empty is ignored (`out_ready` is a don't-care when `out_valid`=0).
- `clear` takes priority over a same-cycle push or pop. It sets pointers, `level`, `phase` and `overflow` to 0. A `ready` in the same cycle is consumed: it neither pushes nor advances `phase`.
- Asynchronous reset mid-operation clears everything immediately, including `primed`. In-flight data is lost.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `level`=0, `overflow`=0. Internally `phase`=0 and `primed`=0.
- Latency: a kept sample is written at the `ready` edge. It appears on `out_valid`/`out_data` in the following cycle if the FIFO was empty.
- `out_data` is registered and always equals `mem[rd_ptr]`. It updates in the cycle after a pop, or after a push into an empty FIFO.
- `out_valid` and `level` are registered. `level` is exact every cycle, with no lag.
- Throughput: one pop per clock. Pushes are at most one per 32·DECIM clocks.
- Once `out_valid` is 1, it stays high until popped or cleared. `out_data` is stable while `out_valid && !out_ready`.

## Structure
- Shared package `voice_pkg` holds:
  - `SAMPLE_W`=8, `FIR_OUT_W`=18 and `COEFF_SHIFT`=10;
  - `sample_t`, a signed [7:0] typedef;
  - a `sat_round` function covering the shift, round and saturate step.
- One sub-module `sample_fifo`, parameterized by DEPTH and width. It provides push/pop/clear, `level`, full/empty and registered head data. `fir_decimator` holds the priming, conversion and phase logic plus the overflow flag.

## Test plan
- Reset, then `ready` pulses 33 clocks apart with `y` = 18'sd5120, 1024, … Outputs: the first strobe is discarded. With DECIM=8, entries appear on primed strobes 1, 9 and 17. `out_data`=5 for y=5120, and `out_valid` rises one cycle after the strobe.
- Rounding and saturation:
  - y=511 → 0; y=512 → 1; y=-512 → 0; y=-513 → -1;
  - y=131071 → 127; y=-131072 → -128.
- Hold `out_ready`=0 for 16 kept samples: `level`=16 and `overflow`=0. The 17th kept sample leaves `level`=16, sets `overflow`=1, and leaves the head unchanged. Drain and check FIFO order 0..15 exactly.
- With the FIFO full, assert `out_ready` on the same cycle as a kept `ready`. Check `level` stays at 16, `overflow`=0, and the new sample lands last.
- Assert `clear` with the FIFO half full and `overflow`=1, on the same cycle as `ready`. Next cycle: `level`=0, `out_valid`=0, `overflow`=0. The next `ready` is kept, since `phase`=0 and the block is still primed.
- Drop `reset` low mid-run between strobes. All outputs go to 0 asynchronously. After release, the first `ready` is discarded again.

Source files
------------

// File: rtl/voice_pkg.sv
// Shared voice-path types and the FIR-output rounding/saturation helper.
package voice_pkg;
    localparam int SAMPLE_W    = 8;
    localparam int FIR_OUT_W   = 18;
    localparam int COEFF_SHIFT = 10;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam logic signed [FIR_OUT_W:0] SAT_MAX = 19'sd127;
    localparam logic signed [FIR_OUT_W:0] SAT_MIN = -19'sd128;

    // Round half up, drop `shift` fractional bits, clamp to the sample range.
    function automatic sample_t sat_round(input logic signed [FIR_OUT_W-1:0] y, input int shift);
        logic signed [FIR_OUT_W:0] sum;
        logic signed [FIR_OUT_W:0] q;
        sum = $signed({y[FIR_OUT_W-1], y}) + $signed((FIR_OUT_W+1)'(1) << (shift - 1));
        q   = sum >>> shift;
        if (q > SAT_MAX)
            sat_round = sample_t'(SAT_MAX[SAMPLE_W-1:0]);
        else if (q < SAT_MIN)
            sat_round = sample_t'(SAT_MIN[SAMPLE_W-1:0]);
        else
            sat_round = sample_t'(q[SAMPLE_W-1:0]);
    endfunction
endpackage

// File: rtl/fir_decimator_if.sv
// Output stream of the decimator plus its FIFO status.
interface fir_decimator_if #(parameter int DEPTH = 16);
    import voice_pkg::*;

    // Handshake: a transfer happens on every rising clock edge where out_valid
    // and out_ready are both 1; out_valid never drops and out_data never changes
    // before that transfer (except on clear/reset); out_ready is ignored when
    // out_valid is 0.
    logic                       out_valid;
    sample_t                    out_data;
    logic                       out_ready;
    logic [$clog2(DEPTH+1)-1:0] level;
    logic                       overflow;

    modport master (output out_valid, out_data, level, overflow, input out_ready);
    modport slave  (input out_valid, out_data, level, overflow, output out_ready);
endinterface

// File: rtl/sample_fifo.sv
// Circular FIFO with exact level count and a registered head word.
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic          valid,
    output logic          full,
    output logic [LW-1:0] level
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic          do_push, do_pop;
    logic [LW-1:0] level_next;

    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr + AW'(1);

    always_comb begin
        level_next = level;
        if (do_push && !do_pop)
            level_next = level + LW'(1);
        else if (do_pop && !do_push)
            level_next = level - LW'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            valid  <= 1'b0;
            head   <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            valid  <= 1'b0;
            head   <= mem[0];
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_next;
            level <= level_next;
            valid <= (level_next != '0);
            // With one entry left, the slot after the head is the one being written now.
            if (do_pop)
                head <= (do_push && level == LW'(1)) ? din : mem[rd_next];
            else if (do_push && !valid)
                head <= din;
        end
    end
endmodule

// File: rtl/fir_decimator.sv
// Captures FIR output on each sample strobe, rounds to 8 bits, keeps every DECIM-th sample into a FIFO.
module fir_decimator
    import voice_pkg::*;
#(
    parameter int DECIM = 8,
    parameter int DEPTH = 16,
    parameter int SHIFT = COEFF_SHIFT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ready,
    input  logic signed [FIR_OUT_W-1:0] y,
    input  logic                        clear,
    fir_decimator_if.master             bus
);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic                primed;
    logic [PW-1:0]       phase;
    logic                overflow;
    logic                strobe, keep;
    logic                fifo_full, fifo_valid;
    logic [LW-1:0]       fifo_level;
    logic [SAMPLE_W-1:0] fifo_head;
    sample_t             sample;

    // The first strobe after reset carries a stale y, so it only primes.
    assign strobe = ready && primed && !clear;
    assign keep   = strobe && (phase == '0);
    assign sample = sat_round(y, SHIFT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            primed   <= 1'b0;
            phase    <= '0;
            overflow <= 1'b0;
        end else begin
            if (ready)
                primed <= 1'b1;
            if (clear) begin
                phase    <= '0;
                overflow <= 1'b0;
            end else begin
                if (strobe)
                    phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
                if (keep && fifo_full && !bus.out_ready)
                    overflow <= 1'b1;
            end
        end
    end

    sample_fifo #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .push  (keep),
        .pop   (bus.out_ready),
        .din   (sample),
        .head  (fifo_head),
        .valid (fifo_valid),
        .full  (fifo_full),
        .level (fifo_level)
    );

    assign bus.out_valid = fifo_valid;
    assign bus.out_data  = sample_t'(fifo_head);
    assign bus.level     = fifo_level;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator: rounding table, decimation, FIFO full/overflow, clear and reset.
module tb_fir_decimator;
  import voice_pkg::*;

  localparam int DECIM = 8;
  localparam int DEPTH = 16;

  typedef struct {
    logic signed [17:0] y;
    int                 exp;
    string              name;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ready = 1'b0;
  logic clear = 1'b0;
  logic signed [17:0] y = '0;

  fir_decimator_if #(.DEPTH(DEPTH)) bus ();

  fir_decimator #(.DECIM(DECIM), .DEPTH(DEPTH), .SHIFT(COEFF_SHIFT)) dut (
    .clock (clock),
    .reset (reset),
    .ready (ready),
    .y     (y),
    .clear (clear),
    .bus   (bus)
  );

  // clock/reset block
  always #5 clock = ~clock;

  // scoreboard state
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  bit         m_primed = 1'b0;
  int         m_phase  = 0;
  bit         m_ovf    = 1'b0;
  vec_t       vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "/out_valid"}, int'(bus.out_valid), int'(exp_q.size() != 0));
    check({tag, "/level"}, int'(bus.level), exp_q.size());
    check({tag, "/overflow"}, int'(bus.overflow), int'(m_ovf));
    if (exp_q.size() != 0)
      check({tag, "/out_data"}, int'($unsigned(bus.out_data)), int'(exp_q[0]));
  endtask

  // driver: one sample strobe 33 clocks after the previous activity
  task automatic send(input logic signed [17:0] v, input int e, input bit pop_too, input bit clr);
    repeat (32) @(negedge clock);
    if (pop_too && exp_q.size() != 0)
      check("pop_with_push/head", int'($unsigned(bus.out_data)), int'(exp_q[0]));
    ready = 1'b1;
    y = v;
    clear = clr;
    bus.out_ready = pop_too;
    @(negedge clock);
    ready = 1'b0;
    clear = 1'b0;
    bus.out_ready = 1'b0;
    if (clr) begin
      exp_q.delete();
      m_phase  = 0;
      m_ovf    = 1'b0;
      m_primed = 1'b1;
    end else begin
      if (pop_too && exp_q.size() != 0)
        void'(exp_q.pop_front());
      if (!m_primed) begin
        m_primed = 1'b1;
      end else begin
        if (m_phase == 0) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(8'(e));
          else m_ovf = 1'b1;
        end
        m_phase = (m_phase + 1) % DECIM;
      end
    end
    check_state("send");
  endtask

  task automatic pop_one();
    if (exp_q.size() == 0) return;
    check("pop/out_data", int'($unsigned(bus.out_data)), int'(exp_q[0]));
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
    void'(exp_q.pop_front());
    check_state("pop");
  endtask

  task automatic drain();
    while (exp_q.size() != 0) pop_one();
  endtask

  task automatic align();
    while (!m_primed || m_phase != 0) send(18'sd0, 0, 1'b0, 1'b0);
  endtask

  task automatic fill(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      align();
      send(18'((base + i) * 1024), base + i, 1'b0, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{18'sd511,     0,    "round_511"};
    vecs[1] = '{18'sd512,     1,    "round_512"};
    vecs[2] = '{-18'sd512,    0,    "round_m512"};
    vecs[3] = '{-18'sd513,    -1,   "round_m513"};
    vecs[4] = '{18'sd131071,  127,  "sat_pos"};
    vecs[5] = '{-18'sd131072, -128, "sat_neg"};
    vecs[6] = '{18'sd5120,    5,    "conv_5120"};
    vecs[7] = '{18'sd1024,    1,    "conv_1024"};

    bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("reset/out_valid", int'(bus.out_valid), 0);
    check("reset/out_data", int'($unsigned(bus.out_data)), 0);
    check("reset/level", int'(bus.level), 0);
    check("reset/overflow", int'(bus.overflow), 0);
    reset = 1'b1;
    @(negedge clock);

    // priming and decimation: strobe 0 dropped, primed strobes 1 and 9 kept
    send(18'sd5120, 5, 1'b0, 1'b0);
    check("prime/discarded", int'(bus.out_valid), 0);
    send(18'sd5120, 5, 1'b0, 1'b0);
    check("latency/out_valid", int'(bus.out_valid), 1);
    check("latency/out_data", int'($unsigned(bus.out_data)), 5);
    for (int i = 0; i < 7; i++) send(18'sd1024, 1, 1'b0, 1'b0);
    check("decim/level_before_9", int'(bus.level), 1);
    send(18'sd3072, 3, 1'b0, 1'b0);
    check("decim/level_after_9", int'(bus.level), 2);
    drain();

    // rounding and saturation table
    for (int i = 0; i < 8; i++) begin
      align();
      send(vecs[i].y, vecs[i].exp, 1'b0, 1'b0);
      check(vecs[i].name, int'($unsigned(bus.out_data)), int'($unsigned(8'(vecs[i].exp))));
      pop_one();
    end

    // full FIFO, then a dropped 17th sample
    fill(0, 16);
    check("full/level", int'(bus.level), 16);
    check("full/overflow", int'(bus.overflow), 0);
    fill(99, 1);
    check("drop/level", int'(bus.level), 16);
    check("drop/overflow", int'(bus.overflow), 1);
    check("drop/head", int'($unsigned(bus.out_data)), 0);
    drain();

    // clear with FIFO half full and overflow set, on a strobe cycle
    fill(40, 8);
    send(18'sd0, 0, 1'b0, 1'b1);
    check("clear/level", int'(bus.level), 0);
    check("clear/out_valid", int'(bus.out_valid), 0);
    check("clear/overflow", int'(bus.overflow), 0);
    send(18'(7 * 1024), 7, 1'b0, 1'b0);
    check("clear/next_kept", int'($unsigned(bus.out_data)), 7);
    pop_one();

    // full FIFO with pop and push on the same edge
    fill(20, 16);
    align();
    send(18'(50 * 1024), 50, 1'b1, 1'b0);
    check("popush/level", int'(bus.level), 16);
    check("popush/overflow", int'(bus.overflow), 0);
    check("popush/head", int'($unsigned(bus.out_data)), 21);
    drain();

    // asynchronous reset between strobes
    fill(60, 1);
    send(18'sd0, 0, 1'b0, 1'b0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("areset/out_valid", int'(bus.out_valid), 0);
    check("areset/out_data", int'($unsigned(bus.out_data)), 0);
    check("areset/level", int'(bus.level), 0);
    check("areset/overflow", int'(bus.overflow), 0);
    exp_q.delete();
    m_primed = 1'b0;
    m_phase  = 0;
    m_ovf    = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    send(18'sd5120, 5, 1'b0, 1'b0);
    check("areset/reprime_discard", int'(bus.out_valid), 0);
    send(18'(61 * 1024), 61, 1'b0, 1'b0);
    check("areset/first_kept", int'($unsigned(bus.out_data)), 61);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
